bcd_event_counter: RTL and testbench

BCD_EVENT_COUNTER -- requirements
Module: bcd_event_counter

---
 rtl/bcd_event_counter_if.sv | 36 +++
 rtl/bcd_event_counter.sv | 118 +++++++++++
 tb/tb_bcd_event_counter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_event_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_event_counter_if
// Groups the event input, control strobes and counter outputs of
// bcd_event_counter.
//   signal   : asynchronous count pulse (falling edge = one event)
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous preload strobe
//   load_val : preload value, 4 bits per BCD digit, digit 0 = ones
//   count    : current BCD value, same packing as load_val
//   roll     : one-cycle pulse when an event hits a terminal value
//   ovf      : sticky boundary flag
// master drives the inputs and observes the outputs; slave is the counter.
// ---------------------------------------------------------------------------
interface bcd_event_counter_if #(
   parameter int DIGITS = 4
);
   logic                  signal;
   logic                  en;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count;
   logic                  roll;
   logic                  ovf;

   modport master (
      output signal, en, up, load, load_val,
      input  count, roll, ovf
   );

   modport slave (
      input  signal, en, up, load, load_val,
      output count, roll, ovf
   );
endinterface

// File: rtl/bcd_event_counter.sv
// ---------------------------------------------------------------------------
// bcd_event_counter
// Multi-digit BCD up/down event counter. Falling edges on an asynchronous
// input are synchronized, edge-detected and counted, with optional
// saturation at all-9s / all-0s, preload with per-digit clamping, a sticky
// overflow flag and a one-cycle roll pulse.
//   clk  : rising-edge clock for all state
//   zero : synchronous active-low clear (highest priority)
//   bus  : bcd_event_counter_if.slave (signal, en, up, load, load_val,
//          count, roll, ovf)
// Parameters: DIGITS (1..8), SAT (1 saturate / 0 wrap),
//             SYNC_STAGES (2..4) synchronizer depth.
// ---------------------------------------------------------------------------
module bcd_event_counter #(
   parameter int DIGITS      = 4,
   parameter int SAT         = 1,
   parameter int SYNC_STAGES = 2
)(
   input logic              clk,
   input logic              zero,
   bcd_event_counter_if.slave bus
);
   localparam int W = 4 * DIGITS;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   dly_reg;
   logic                   evt_reg;
   logic [W-1:0]           count_reg, count_next;
   logic                   ovf_reg, ovf_next;
   logic                   roll_reg, roll_next;

   logic [W-1:0]           inc_val, dec_val, clamp_val;
   // carry[k] = every digit below k is 9 (increment ripples into digit k);
   // borrow[k] = every digit below k is 0. The top entries flag all-9s /
   // all-0s, i.e. the terminal boundaries.
   logic [DIGITS:0]        carry, borrow;

   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] d;
         logic [3:0] lv;
         assign d  = count_reg[4*gi +: 4];
         assign lv = bus.load_val[4*gi +: 4];

         assign carry[gi+1]  = carry[gi]  & (d == 4'd9);
         assign borrow[gi+1] = borrow[gi] & (d == 4'd0);

         // Wrapping per-digit step; at all-9s / all-0s this naturally
         // yields all-0s / all-9s, which is the SAT=0 wrap value.
         assign inc_val[4*gi +: 4] = !carry[gi]     ? d     :
                                     (d == 4'd9)    ? 4'd0  : d + 4'd1;
         assign dec_val[4*gi +: 4] = !borrow[gi]    ? d     :
                                     (d == 4'd0)    ? 4'd9  : d - 4'd1;

         assign clamp_val[4*gi +: 4] = (lv > 4'd9) ? 4'd9 : lv;
      end
   endgenerate

   // Synchronizer, one-flop delay and a registered event strobe. The
   // strobe register puts the count update SYNC_STAGES+2 edges after the
   // edge that first samples the falling input. Reset clears everything to
   // 0, so an input already low at release cannot produce an event.
   always_ff @(posedge clk) begin
      if (!zero) begin
         sync_reg  <= '0;
         dly_reg   <= 1'b0;
         evt_reg   <= 1'b0;
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         roll_reg  <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], bus.signal};
         dly_reg   <= sync_reg[SYNC_STAGES-1];
         evt_reg   <= dly_reg & ~sync_reg[SYNC_STAGES-1];
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         roll_reg  <= roll_next;
      end
   end

   // Load beats a coincident event; events with en=0 are simply dropped.
   always_comb begin
      count_next = count_reg;
      ovf_next   = ovf_reg;
      roll_next  = 1'b0;
      if (bus.load) begin
         count_next = clamp_val;
         ovf_next   = 1'b0;
      end else if (evt_reg && bus.en) begin
         if (bus.up) begin
            if (carry[DIGITS]) begin
               ovf_next  = 1'b1;
               roll_next = 1'b1;
               if (SAT == 0) count_next = inc_val;
            end else begin
               count_next = inc_val;
            end
         end else begin
            if (borrow[DIGITS]) begin
               ovf_next  = 1'b1;
               roll_next = 1'b1;
               if (SAT == 0) count_next = dec_val;
            end else begin
               count_next = dec_val;
            end
         end
      end
   end

   assign bus.count = count_reg;
   assign bus.ovf   = ovf_reg;
   assign bus.roll  = roll_reg;

endmodule

// File: tb/tb_bcd_event_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_event_counter
// Drives three counter variants from shared stimulus:
//   d0: DIGITS=4 SAT=1, d1: DIGITS=4 SAT=0, d2: DIGITS=2 SAT=1.
// A decimal-integer model predicts each variant; expectations are queued
// when stimulus is applied and compared when the result is due.
// ---------------------------------------------------------------------------
module tb_bcd_event_counter;
   localparam int ND = 3;

   logic        clk = 1'b0;
   logic        zero;
   logic        sig, en, up, load;
   logic [31:0] lv;

   always #5 clk = ~clk;

   bcd_event_counter_if #(.DIGITS(4)) ifa ();
   bcd_event_counter_if #(.DIGITS(4)) ifb ();
   bcd_event_counter_if #(.DIGITS(2)) ifc ();

   assign ifa.signal = sig;  assign ifb.signal = sig;  assign ifc.signal = sig;
   assign ifa.en     = en;   assign ifb.en     = en;   assign ifc.en     = en;
   assign ifa.up     = up;   assign ifb.up     = up;   assign ifc.up     = up;
   assign ifa.load   = load; assign ifb.load   = load; assign ifc.load   = load;
   assign ifa.load_val = lv[15:0];
   assign ifb.load_val = lv[15:0];
   assign ifc.load_val = lv[7:0];

   bcd_event_counter #(.DIGITS(4), .SAT(1), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .zero(zero), .bus(ifa));
   bcd_event_counter #(.DIGITS(4), .SAT(0), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .zero(zero), .bus(ifb));
   bcd_event_counter #(.DIGITS(2), .SAT(1), .SYNC_STAGES(2)) dut_c (
      .clk(clk), .zero(zero), .bus(ifc));

   // ---------------- model ----------------
   int          digs [ND] = '{4, 4, 2};
   int          sats [ND] = '{1, 0, 1};
   int unsigned mv   [ND];
   bit          mo   [ND];
   bit          mr   [ND];
   int          mrolls [ND];
   int          rolls_seen [ND];

   typedef struct {
      int          dut;
      logic [31:0] cnt;
      logic        ovf;
      logic        roll;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   function automatic int unsigned maxv(input int d);
      int unsigned r = 1;
      for (int k = 0; k < d; k++) r = r * 10;
      return r - 1;
   endfunction

   function automatic logic [31:0] to_bcd(input int unsigned v, input int d);
      logic [31:0] r = '0;
      int unsigned x = v;
      for (int k = 0; k < d; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic void model_event();
      for (int i = 0; i < ND; i++) begin
         mr[i] = 1'b0;
         if (en) begin
            if (up) begin
               if (mv[i] == maxv(digs[i])) begin
                  mo[i] = 1'b1; mr[i] = 1'b1; mrolls[i]++;
                  if (sats[i] == 0) mv[i] = 0;
               end else mv[i] = mv[i] + 1;
            end else begin
               if (mv[i] == 0) begin
                  mo[i] = 1'b1; mr[i] = 1'b1; mrolls[i]++;
                  if (sats[i] == 0) mv[i] = maxv(digs[i]);
               end else mv[i] = mv[i] - 1;
            end
         end
      end
   endfunction

   function automatic void model_load(input logic [31:0] v);
      for (int i = 0; i < ND; i++) begin
         int unsigned val = 0;
         int unsigned mult = 1;
         for (int k = 0; k < digs[i]; k++) begin
            int unsigned nib = int'(v[4*k +: 4]);
            if (nib > 9) nib = 9;
            val  = val + nib * mult;
            mult = mult * 10;
         end
         mv[i] = val; mo[i] = 1'b0; mr[i] = 1'b0;
      end
   endfunction

   function automatic void model_zero();
      for (int i = 0; i < ND; i++) begin
         mv[i] = 0; mo[i] = 1'b0; mr[i] = 1'b0;
      end
   endfunction

   function automatic void push_exp();
      for (int i = 0; i < ND; i++) begin
         exp_t e;
         e.dut = i; e.cnt = to_bcd(mv[i], digs[i]); e.ovf = mo[i]; e.roll = mr[i];
         sb.push_back(e);
      end
   endfunction

   function automatic logic [31:0] act_cnt(input int i);
      case (i)
         0:       return {16'h0, ifa.count};
         1:       return {16'h0, ifb.count};
         default: return {24'h0, ifc.count};
      endcase
   endfunction

   function automatic logic act_ovf(input int i);
      case (i)
         0:       return ifa.ovf;
         1:       return ifb.ovf;
         default: return ifc.ovf;
      endcase
   endfunction

   function automatic logic act_roll(input int i);
      case (i)
         0:       return ifa.roll;
         1:       return ifb.roll;
         default: return ifc.roll;
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val($sformatf("%s.d%0d.count", tag, e.dut), act_cnt(e.dut), e.cnt);
         check_val($sformatf("%s.d%0d.ovf", tag, e.dut), {31'h0, act_ovf(e.dut)}, {31'h0, e.ovf});
         check_val($sformatf("%s.d%0d.roll", tag, e.dut), {31'h0, act_roll(e.dut)}, {31'h0, e.roll});
      end
      $display("txn %-12s a=%h/%b b=%h/%b c=%h/%b", tag, ifa.count, ifa.ovf,
               ifb.count, ifb.ovf, ifc.count, ifc.ovf);
   endtask

   always @(posedge clk) begin
      if (ifa.roll === 1'b1) rolls_seen[0]++;
      if (ifb.roll === 1'b1) rolls_seen[1]++;
      if (ifc.roll === 1'b1) rolls_seen[2]++;
   end

   // ---------------- stimulus ----------------
   task automatic pulse(input string tag);
      @(negedge clk); sig = 1'b0; model_event(); push_exp();
      repeat (4) @(negedge clk);
      sb_check(tag);
      sig = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_load(input logic [31:0] v, input string tag);
      @(negedge clk); lv = v; load = 1'b1; model_load(v); push_exp();
      @(negedge clk); load = 1'b0;
      sb_check(tag);
   endtask

   task automatic do_zero(input string tag);
      @(negedge clk); zero = 1'b0; model_zero(); push_exp();
      @(negedge clk); zero = 1'b1;
      sb_check(tag);
   endtask

   // Load lands on the same edge as the event strobe; the event is lost.
   task automatic load_with_event(input logic [31:0] v, input string tag);
      @(negedge clk); sig = 1'b0;
      repeat (3) @(negedge clk);
      lv = v; load = 1'b1; model_load(v); push_exp();
      @(negedge clk); load = 1'b0;
      sb_check(tag);
      sig = 1'b1;
      repeat (3) @(negedge clk);
      push_exp();
      sb_check({tag, "_after"});
   endtask

   // Clear while a falling edge is still in the synchronizer.
   task automatic zero_inflight(input string tag);
      @(negedge clk); sig = 1'b0;
      @(negedge clk); zero = 1'b0; model_zero(); push_exp();
      @(negedge clk); zero = 1'b1;
      sb_check(tag);
      repeat (5) @(negedge clk);
      push_exp();
      sb_check({tag, "_lost"});
      sig = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      sig = 1'b0; zero = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; lv = '0;
      for (int i = 0; i < ND; i++) begin mrolls[i] = 0; rolls_seen[i] = 0; end
      model_zero();

      repeat (3) @(negedge clk);
      push_exp();
      sb_check("reset");

      // signal held low through release: no event
      zero = 1'b1;
      repeat (6) @(negedge clk);
      push_exp();
      sb_check("held_low");
      sig = 1'b1;
      repeat (3) @(negedge clk);

      // first event: measure the edge that updates count
      @(negedge clk); sig = 1'b0; model_event(); push_exp();
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         if (lat == 0 && ifa.count !== 16'h0000) lat = i;
      end
      @(negedge clk);
      sb_check("first");
      check_val("latency", lat, 32'd4);
      sig = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 1; i < 1234; i++) pulse("count");
      check_val("count1234", act_cnt(0), 32'h1234);

      en = 1'b0;
      repeat (5) pulse("en_off");
      en = 1'b1;
      pulse("en_on");

      do_load(32'h9998, "load_9998");
      repeat (3) pulse("sat_up");

      do_load(32'h0001, "load_0001");
      up = 1'b0;
      repeat (2) pulse("down");
      do_load(32'h00AF, "load_clamp");

      up = 1'b1;
      load_with_event(32'h0042, "load_evt");
      pulse("after_load");
      up = 1'b0; pulse("dir_dn");
      up = 1'b1; pulse("dir_up");

      do_load(32'h9999, "load_9999");
      pulse("ovf_set");
      do_zero("zero_mid");
      pulse("post_zero");
      zero_inflight("inflight");

      repeat (100) pulse("hundred");
      up = 1'b0;
      pulse("borrow");

      repeat (4) @(negedge clk);
      for (int i = 0; i < ND; i++)
         check_val($sformatf("rolls.d%0d", i), rolls_seen[i], mrolls[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
